// File: rtl/rr_mux_arbiter.sv
// NCH-channel valid/ready arbiter (round-robin or fixed priority) into one registered output slot.
// Latency 1 cycle; the slot refills on the same edge it drains; in_ready drops while the slot is full and stalled.
module rr_mux_arbiter #(
  parameter int N    = 32,
  parameter int NCH  = 4,
  parameter int MODE = 0,
  parameter int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*N-1:0]  in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  output logic [N-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SELW-1:0]   out_sel
);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] winner;
  logic [N-1:0]    win_data;
  logic            any_req;
  logic            load_en;

  assign any_req = |in_valid;
  assign load_en = ~out_valid | out_ready;

  // Winner is the requester with the smallest distance from ptr (round-robin)
  // or the smallest index (fixed priority).
  always_comb begin : arb
    int best;
    int off;
    best   = NCH;
    off    = 0;
    winner = '0;
    for (int i = 0; i < NCH; i++) begin
      if (MODE == 0) begin
        off = i - int'(ptr);
        if (off < 0) off = off + NCH;
      end else begin
        off = i;
      end
      if (in_valid[i] && (off < best)) begin
        best   = off;
        winner = SELW'(i);
      end
    end
  end

  always_comb begin
    win_data = '0;
    in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      if (winner == SELW'(i)) begin
        win_data    = in_data[i*N +: N];
        in_ready[i] = rst_n & load_en & any_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (any_req) begin
        out_data  <= win_data;
        out_sel   <= winner;
        out_valid <= 1'b1;
        // Wrap at NCH, not 2^SELW, so non-power-of-2 channel counts stay in range.
        if (MODE == 0) begin
          ptr <= (winner == SELW'(NCH - 1)) ? '0 : winner + 1'b1;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: round-robin NCH=4, fixed-priority NCH=4, round-robin NCH=3.
// Per-cycle vector table plus hand-written reset sequences.
module tb_rr_mux_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut 0: round-robin, 4 channels, data A0+i
  logic [127:0] d4;
  logic [3:0]   v4, r4;
  logic [31:0]  od4;
  logic         ov4, or4;
  logic [1:0]   os4;
  // dut 1: fixed priority, 4 channels, data B0+i
  logic [127:0] dp;
  logic [3:0]   vp, rp;
  logic [31:0]  odp;
  logic         ovp, orp;
  logic [1:0]   osp;
  // dut 2: round-robin, 3 channels, data C0+i
  logic [95:0]  d3;
  logic [2:0]   v3, r3;
  logic [31:0]  od3;
  logic         ov3, or3;
  logic [1:0]   os3;

  rr_mux_arbiter #(.N(32), .NCH(4), .MODE(0)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .in_valid(v4), .in_ready(r4),
    .out_data(od4), .out_valid(ov4), .out_ready(or4), .out_sel(os4));

  rr_mux_arbiter #(.N(32), .NCH(4), .MODE(1)) u_fp4 (
    .clk(clk), .rst_n(rst_n), .in_data(dp), .in_valid(vp), .in_ready(rp),
    .out_data(odp), .out_valid(ovp), .out_ready(orp), .out_sel(osp));

  rr_mux_arbiter #(.N(32), .NCH(3), .MODE(0)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3), .in_ready(r3),
    .out_data(od3), .out_valid(ov3), .out_ready(or3), .out_sel(os3));

  typedef struct {
    int          dut;
    logic [3:0]  vld;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [3:0]  exp_sel;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s[%0d]: got %h, want %h", name, idx, act, exp);
    end
  endtask

  // Target DUT gets the given request pattern; the others stay idle with out_ready high.
  task automatic drive(input int dut, input logic [3:0] vld, input logic ordy);
    v4 = '0; or4 = 1'b1;
    vp = '0; orp = 1'b1;
    v3 = '0; or3 = 1'b1;
    case (dut)
      0: begin v4 = vld;      or4 = ordy; end
      1: begin vp = vld;      orp = ordy; end
      default: begin v3 = vld[2:0]; or3 = ordy; end
    endcase
  endtask

  task automatic get_out(input int dut, output logic [3:0] rdy, output logic ov,
                         output logic [3:0] sel, output logic [31:0] dat);
    case (dut)
      0: begin rdy = r4;          ov = ov4; sel = {2'b00, os4}; dat = od4; end
      1: begin rdy = rp;          ov = ovp; sel = {2'b00, osp}; dat = odp; end
      default: begin rdy = {1'b0, r3}; ov = ov3; sel = {2'b00, os3}; dat = od3; end
    endcase
  endtask

  initial begin
    logic [3:0]  a_rdy;
    logic        a_ov;
    logic [3:0]  a_sel;
    logic [31:0] a_dat;

    for (int i = 0; i < 4; i++) begin
      d4[i*32 +: 32] = 32'hA0 + i;
      dp[i*32 +: 32] = 32'hB0 + i;
    end
    for (int i = 0; i < 3; i++) d3[i*32 +: 32] = 32'hC0 + i;

    // round-robin 4: wrap, back-pressure, sparse requests, empty slot
    tbl.push_back('{0, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'd0, 32'hA0});
    tbl.push_back('{0, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'd1, 32'hA1});
    tbl.push_back('{0, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'd2, 32'hA2});
    tbl.push_back('{0, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'd3, 32'hA3});
    tbl.push_back('{0, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'd0, 32'hA0});
    tbl.push_back('{0, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'd1, 32'hA1});
    tbl.push_back('{0, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'd1, 32'hA1});
    tbl.push_back('{0, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'd1, 32'hA1});
    tbl.push_back('{0, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'd1, 32'hA1});
    tbl.push_back('{0, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'd2, 32'hA2});
    tbl.push_back('{0, 4'b0001, 1'b1, 4'b0001, 1'b1, 4'd0, 32'hA0});
    tbl.push_back('{0, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'd0, 32'hA0});
    tbl.push_back('{0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'd0, 32'hA0});
    tbl.push_back('{0, 4'b1000, 1'b0, 4'b1000, 1'b1, 4'd3, 32'hA3});
    tbl.push_back('{0, 4'b0110, 1'b0, 4'b0000, 1'b1, 4'd3, 32'hA3});
    tbl.push_back('{0, 4'b0110, 1'b1, 4'b0010, 1'b1, 4'd1, 32'hA1});
    tbl.push_back('{0, 4'b0110, 1'b1, 4'b0100, 1'b1, 4'd2, 32'hA2});
    tbl.push_back('{0, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'd1, 32'hA1});
    // fixed priority 4
    tbl.push_back('{1, 4'b1010, 1'b1, 4'b0010, 1'b1, 4'd1, 32'hB1});
    tbl.push_back('{1, 4'b1010, 1'b1, 4'b0010, 1'b1, 4'd1, 32'hB1});
    tbl.push_back('{1, 4'b1010, 1'b1, 4'b0010, 1'b1, 4'd1, 32'hB1});
    tbl.push_back('{1, 4'b1000, 1'b1, 4'b1000, 1'b1, 4'd3, 32'hB3});
    tbl.push_back('{1, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'd0, 32'hB0});
    tbl.push_back('{1, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'd0, 32'hB0});
    // round-robin 3: ptr wraps at 3
    tbl.push_back('{2, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'd1, 32'hC1});
    tbl.push_back('{2, 4'b0001, 1'b1, 4'b0001, 1'b1, 4'd0, 32'hC0});
    tbl.push_back('{2, 4'b0111, 1'b1, 4'b0010, 1'b1, 4'd1, 32'hC1});
    tbl.push_back('{2, 4'b0111, 1'b1, 4'b0100, 1'b1, 4'd2, 32'hC2});
    tbl.push_back('{2, 4'b0111, 1'b1, 4'b0001, 1'b1, 4'd0, 32'hC0});
    tbl.push_back('{2, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'd0, 32'hC0});

    // reset state with requests pending
    drive(0, 4'b1111, 1'b1);
    #2;
    chk("rst_in_ready", 0, {28'd0, r4}, 32'd0);
    chk("rst_out_valid", 0, {31'd0, ov4}, 32'd0);
    chk("rst_out_sel", 0, {30'd0, os4}, 32'd0);
    chk("rst_out_data", 0, od4, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 4'b0000, 1'b1);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      drive(tbl[k].dut, tbl[k].vld, tbl[k].ordy);
      #1;
      get_out(tbl[k].dut, a_rdy, a_ov, a_sel, a_dat);
      chk("in_ready", k, {28'd0, a_rdy}, {28'd0, tbl[k].exp_rdy});
      @(posedge clk);
      #1;
      get_out(tbl[k].dut, a_rdy, a_ov, a_sel, a_dat);
      chk("out_valid", k, {31'd0, a_ov}, {31'd0, tbl[k].exp_ov});
      chk("out_sel", k, {28'd0, a_sel}, {28'd0, tbl[k].exp_sel});
      chk("out_data", k, a_dat, tbl[k].exp_dat);
    end

    // reset mid-stream with the slot full: outputs clear without waiting for a clock
    @(negedge clk);
    drive(0, 4'b1111, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 0, {31'd0, ov4}, 32'd1);
    chk("pre_rst_sel", 0, {30'd0, os4}, 32'd2);
    chk("pre_rst_data", 0, od4, 32'hA2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 0, {31'd0, ov4}, 32'd0);
    chk("mid_rst_sel", 0, {30'd0, os4}, 32'd0);
    chk("mid_rst_data", 0, od4, 32'd0);
    chk("mid_rst_ready", 0, {28'd0, r4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 4'b1111, 1'b1);
    #1;
    chk("post_rst_ready", 0, {28'd0, r4}, 32'd1);
    @(posedge clk);
    #1;
    chk("post_rst_valid", 0, {31'd0, ov4}, 32'd1);
    chk("post_rst_sel", 0, {30'd0, os4}, 32'd0);
    chk("post_rst_data", 0, od4, 32'hA0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Parametrised N-bit, NCH-channel successor to the fixed 4:1 combinational select mux.
- Arbitrates between valid/ready input channels and forwards one word per cycle into a single registered output slot.
- Selection is round-robin or fixed-priority; the selected channel index is reported alongside the data.
- Sits between multiple requesters (e.g. fetch/LSU sources) and one shared downstream consumer in the RV32IC core.

Parameters:
- N, 32, data width per channel (>=1)
- NCH, 4, number of input channels (2..16)
- MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
- SELW, clog2(NCH), width of the select/grant index (derived; minimum 1)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  NCH*N  packed channel data; channel i occupies bits [i*N+N-1 : i*N]
- in_valid  input  NCH  per-channel request valid
- in_ready  output  NCH  per-channel accept; one-hot or zero, combinational
- out_data  output  N  registered data of the accepted word
- out_valid  output  1  output slot holds a word
- out_ready  input  1  downstream accepts when out_valid & out_ready
- out_sel  output  SELW  channel index that produced out_data

Behaviour:
- Reset (async assert, sync release on the next clk edge):
  - out_valid = 0, out_data = 0, out_sel = 0, rr pointer ptr = 0.
  - in_ready = 0 while rst_n is low.
- Slot state (implicit two-state FSM):
  - EMPTY when out_valid = 0; FULL when out_valid = 1.
  - load_en = ~out_valid | out_ready (slot free this cycle, or being drained this cycle).
- Arbitration (combinational, evaluated every cycle):
  - MODE 0: winner = first i with in_valid[i], scanning ptr, ptr+1, …, NCH-1, 0, …, ptr-1 (wrap modulo NCH).
  - MODE 1: winner = lowest i with in_valid[i]; ptr is unused and stays 0.
  - any_req = |in_valid.
- Handshake:
  - in_ready[winner] = load_en & any_req. All other in_ready bits = 0. in_ready = 0 when any_req = 0.
  - An input transfer occurs when in_valid[i] & in_ready[i].
  - in_ready never depends on in_data. It may depend on in_valid and out_ready; downstream must not combinationally loop out_ready from in_ready.
- Register update at clk edge when load_en:
  - If any_req: out_data = in_data[winner], out_sel = winner, out_valid = 1. MODE 0 only: ptr = winner+1, wrapping NCH-1 -> 0.
  - If no request: out_valid = 0. out_data and out_sel hold their last value.
- When load_en = 0 (FULL and stalled): all registers hold; out_data and out_sel stay stable while out_valid = 1.
- Latency and throughput:
  - Exactly 1 cycle from input transfer to out_valid.
  - Full throughput of one word per cycle with out_ready held high.
- Fairness (MODE 0): a channel that stays valid is granted within NCH transfers.
- Simultaneous drain and load in the same cycle: the slot is refilled with no bubble.
- Non-power-of-2 NCH: ptr wraps at NCH, not at 2^SELW. Indices >= NCH are never produced.
- Reset asserted mid-transfer: the in-flight word is discarded and outputs return to reset values immediately (asynchronously).
- Input protocol: after asserting in_valid, a source holds in_valid and in_data stable until accepted. The block does not check this.

Test Plan:
- Reset: drive rst_n=0 mid-stream with out_valid=1 -> out_valid, out_data, out_sel drop to 0 within the same cycle; in_ready=0; first grant after release goes to channel 0 when all valid.
- Round-robin wrap: NCH=4, MODE=0, all in_valid=1, in_data[i]=32'hA0+i, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 at one word per cycle; out_data = A0,A1,A2,A3,A0.
- Back-pressure: out_ready=0 for 3 cycles with slot FULL (out_data=32'hA1) -> in_ready=0, out_data/out_sel held; on out_ready=1 the next word is loaded in the same edge with no bubble.
- Fixed priority: MODE=1, in_valid=4'b1010 -> channel 1 granted every cycle; drop in_valid[1] -> channel 3 granted next cycle.
- Sparse/odd NCH: NCH=3, MODE=0, ptr=2, only in_valid[0]=1 -> winner 0, ptr becomes 1; out_sel never reaches 3. With no requests and out_ready=1, out_valid falls to 0 the following cycle.
